// File: rtl/cpu6_regfile_sb_pkg.sv
// Shared widths and sequencer state codes for the cpu6 integer register file.
package cpu6_regfile_sb_pkg;

  localparam int unsigned CPU6_XLEN        = 32;
  localparam int unsigned CPU6_RFIDX_WIDTH = 5;

  localparam logic CPU6_RF_ST_CLR = 1'b0;
  localparam logic CPU6_RF_ST_RUN = 1'b1;

  typedef enum logic {
    StClr = CPU6_RF_ST_CLR,
    StRun = CPU6_RF_ST_RUN
  } rf_state_e;

endpackage

// File: rtl/cpu6_rf_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared by writeback, flushed on clear sweep.
module cpu6_rf_scoreboard
  import cpu6_regfile_sb_pkg::*;
#(
  parameter int unsigned RFIDX_W = CPU6_RFIDX_WIDTH,
  parameter int unsigned NRD     = 2,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   flush,
  input  logic                   set_en,
  input  logic [RFIDX_W-1:0]     set_idx,
  input  logic                   clr_a_en,
  input  logic [RFIDX_W-1:0]     clr_a_idx,
  input  logic                   clr_b_en,
  input  logic [RFIDX_W-1:0]     clr_b_idx,
  input  logic [NRD*RFIDX_W-1:0] rd_idx,
  output logic [NRD-1:0]         rd_busy
);

  localparam int unsigned NREGS = 2 ** RFIDX_W;

  logic [NREGS-1:0]   busy_q, busy_d;
  logic [RFIDX_W-1:0] sel;

  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_a_en) busy_d[clr_a_idx] = 1'b0;
      if (clr_b_en) busy_d[clr_b_idx] = 1'b0;
      // Applied last: a newly issued producer outranks an older one retiring.
      if (set_en)   busy_d[set_idx]   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_busy = '0;
    sel     = '0;
    for (int k = 0; k < NRD; k++) begin
      sel        = rd_idx[k*RFIDX_W +: RFIDX_W];
      rd_busy[k] = run & busy_q[sel] &
                   ~(BYPASS & ((clr_a_en & (clr_a_idx == sel)) |
                               (clr_b_en & (clr_b_idx == sel))));
    end
  end

endmodule

// File: rtl/cpu6_regfile_sb.sv
// cpu6 integer register file: NRD read ports, ALU/load write ports, optional bypass,
// busy scoreboard, and a post-reset sweep that zeroes the unreset storage.
module cpu6_regfile_sb
  import cpu6_regfile_sb_pkg::*;
#(
  parameter int unsigned XLEN    = CPU6_XLEN,
  parameter int unsigned RFIDX_W = CPU6_RFIDX_WIDTH,
  parameter int unsigned NRD     = 2,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   init_done,
  input  logic                   sw_clr,
  input  logic [NRD*RFIDX_W-1:0] rd_idx,
  output logic [NRD*XLEN-1:0]    rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic                   wa_wen,
  input  logic [RFIDX_W-1:0]     wa_idx,
  input  logic [XLEN-1:0]        wa_data,
  input  logic                   wb_wen,
  input  logic [RFIDX_W-1:0]     wb_idx,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   iss_valid,
  input  logic [RFIDX_W-1:0]     iss_idx
);

  localparam int unsigned NREGS = 2 ** RFIDX_W;

  rf_state_e          state_q, state_d;
  logic [RFIDX_W-1:0] cnt_q, cnt_d;
  logic               run, clr_we, wa_ok, wb_ok, iss_ok, flush;
  logic [RFIDX_W-1:0] sel;
  logic [XLEN-1:0]    mem [NREGS];

  assign run       = (state_q == StRun);
  assign init_done = run;
  assign wa_ok     = run & wa_wen & (wa_idx != '0);
  // Port B loses a same-index collision with port A.
  assign wb_ok     = run & wb_wen & (wb_idx != '0) & ~(wa_ok & (wa_idx == wb_idx));
  assign iss_ok    = run & iss_valid & (iss_idx != '0);
  assign flush     = run & sw_clr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      StClr: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + RFIDX_W'(1);
        if (cnt_q == {RFIDX_W{1'b1}}) state_d = StRun;
        if (sw_clr) begin
          state_d = StClr;
          cnt_d   = RFIDX_W'(1);
        end
      end
      StRun: begin
        if (sw_clr) begin
          state_d = StClr;
          cnt_d   = RFIDX_W'(1);
        end
      end
      default: state_d = StClr;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StClr;
      cnt_q   <= RFIDX_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // No reset on storage so it can map onto RAM; x0 is never written and masked on read.
  always_ff @(posedge clk) begin
    if (clr_we) mem[cnt_q]  <= '0;
    if (wa_ok)  mem[wa_idx] <= wa_data;
    if (wb_ok)  mem[wb_idx] <= wb_data;
  end

  always_comb begin
    rd_data = '0;
    sel     = '0;
    for (int k = 0; k < NRD; k++) begin
      sel = rd_idx[k*RFIDX_W +: RFIDX_W];
      if (run && sel != '0) begin
        if (BYPASS && wa_ok && wa_idx == sel) begin
          rd_data[k*XLEN +: XLEN] = wa_data;
        end else if (BYPASS && wb_ok && wb_idx == sel) begin
          rd_data[k*XLEN +: XLEN] = wb_data;
        end else begin
          rd_data[k*XLEN +: XLEN] = mem[sel];
        end
      end
    end
  end

  cpu6_rf_scoreboard #(
    .RFIDX_W (RFIDX_W),
    .NRD     (NRD),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .flush     (flush),
    .set_en    (iss_ok),
    .set_idx   (iss_idx),
    .clr_a_en  (wa_ok),
    .clr_a_idx (wa_idx),
    .clr_b_en  (wb_ok),
    .clr_b_idx (wb_idx),
    .rd_idx    (rd_idx),
    .rd_busy   (rd_busy)
  );

endmodule

// File: tb/tb_cpu6_regfile_sb.sv
// Bench for cpu6_regfile_sb: bypass and non-bypass instances share stimulus and are checked
// against hand vectors and an array-based model of the register file rules.
module tb_cpu6_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sw_clr = 1'b0;
  logic [9:0]  rd_idx = '0;
  logic        wa_wen = 1'b0, wb_wen = 1'b0, iss_valid = 1'b0;
  logic [4:0]  wa_idx = '0, wb_idx = '0, iss_idx = '0;
  logic [31:0] wa_data = '0, wb_data = '0;

  logic        init_done_b, init_done_n;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;

  always #5 clk = ~clk;

  cpu6_regfile_sb #(.XLEN(32), .RFIDX_W(5), .NRD(2), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .init_done(init_done_b), .sw_clr(sw_clr),
    .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wa_wen(wa_wen), .wa_idx(wa_idx), .wa_data(wa_data),
    .wb_wen(wb_wen), .wb_idx(wb_idx), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_idx(iss_idx)
  );

  cpu6_regfile_sb #(.XLEN(32), .RFIDX_W(5), .NRD(2), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .init_done(init_done_n), .sw_clr(sw_clr),
    .rd_idx(rd_idx), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wa_wen(wa_wen), .wa_idx(wa_idx), .wa_data(wa_data),
    .wb_wen(wb_wen), .wb_idx(wb_idx), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_idx(iss_idx)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register contents, busy flags, and clear-sweep cycles remaining.
  logic [31:0] m_reg [32];
  bit          m_busy [32];
  int          m_left = 31;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_left = 31;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  function automatic void model_read(input bit byp, input logic [4:0] idx,
                                     output logic [31:0] d, output logic b);
    bit wa_hit, wb_hit;
    d = '0;
    b = 1'b0;
    if (m_left == 0 && idx != 0) begin
      d = m_reg[idx];
      b = m_busy[idx];
      wa_hit = wa_wen && wa_idx == idx;
      wb_hit = wb_wen && wb_idx == idx;
      if (byp) begin
        if (wa_hit) d = wa_data;
        else if (wb_hit) d = wb_data;
        if (wa_hit || wb_hit) b = 1'b0;
      end
    end
  endfunction

  task automatic model_step();
    if (m_left == 0) begin
      if (wa_wen && wa_idx != 0) m_reg[wa_idx] = wa_data;
      if (wb_wen && wb_idx != 0 && !(wa_wen && wa_idx == wb_idx)) m_reg[wb_idx] = wb_data;
      if (sw_clr) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_left = 31;
      end else begin
        if (wa_wen && wa_idx != 0) m_busy[wa_idx] = 1'b0;
        if (wb_wen && wb_idx != 0) m_busy[wb_idx] = 1'b0;
        if (iss_valid && iss_idx != 0) m_busy[iss_idx] = 1'b1;
      end
    end else if (sw_clr) begin
      m_left = 31;
    end else begin
      m_left--;
      if (m_left == 0) for (int i = 0; i < 32; i++) m_reg[i] = '0;
    end
  endtask

  task automatic check_model();
    logic [31:0] d;
    logic        b;
    chk("init_done_byp", {31'd0, init_done_b}, {31'd0, m_left == 0});
    chk("init_done_nb", {31'd0, init_done_n}, {31'd0, m_left == 0});
    for (int k = 0; k < 2; k++) begin
      model_read(1'b1, rd_idx[k*5 +: 5], d, b);
      chk($sformatf("data_byp[%0d] idx %0d", k, rd_idx[k*5 +: 5]), rd_data_b[k*32 +: 32], d);
      chk($sformatf("busy_byp[%0d] idx %0d", k, rd_idx[k*5 +: 5]), {31'd0, rd_busy_b[k]},
          {31'd0, b});
      model_read(1'b0, rd_idx[k*5 +: 5], d, b);
      chk($sformatf("data_nb[%0d] idx %0d", k, rd_idx[k*5 +: 5]), rd_data_n[k*32 +: 32], d);
      chk($sformatf("busy_nb[%0d] idx %0d", k, rd_idx[k*5 +: 5]), {31'd0, rd_busy_n[k]},
          {31'd0, b});
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    wa_wen = 1'b0; wb_wen = 1'b0; iss_valid = 1'b0; sw_clr = 1'b0;
    wa_idx = '0; wb_idx = '0; iss_idx = '0; wa_data = '0; wb_data = '0;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (init_done_b !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk(name, 32'(n), 32'd31);
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_init_done", {31'd0, init_done_b}, 32'd0);
    chk("async_rst_busy", {30'd0, rd_busy_n}, 32'd0);
    rst = 1'b1;
    #1;
  endtask

  typedef struct {
    logic        wa_wen;  logic [4:0] wa_idx;  logic [31:0] wa_data;
    logic        wb_wen;  logic [4:0] wb_idx;  logic [31:0] wb_data;
    logic        iss;     logic [4:0] iss_idx;
    logic [4:0]  r0;      logic [4:0] r1;
    logic [31:0] eb0, eb1, en0, en1;
    logic [1:0]  bb, bn;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0,
                32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00};
    tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5,
                32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 2'b00};
    tbl[2]  = '{1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7,
                32'h11, 32'h11, 32'h0, 32'h0, 2'b00, 2'b00};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 5'd0, 5'd7,
                32'h0, 32'h11, 32'h0, 32'h11, 2'b00, 2'b00};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0,
                32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00};
    tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                32'h0, 32'h0, 32'h0, 32'h0, 2'b11, 2'b11};
    tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd9, 5'd0,
                32'h99, 32'h0, 32'h0, 32'h0, 2'b00, 2'b01};
    tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                32'h99, 32'h99, 32'h99, 32'h99, 2'b11, 2'b11};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 5'd9, 5'd5,
                32'h77, 32'hDEADBEEF, 32'h99, 32'hDEADBEEF, 2'b00, 2'b01};
    tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5,
                32'h77, 32'hDEADBEEF, 32'h77, 32'hDEADBEEF, 2'b00, 2'b00};
    tbl[10] = '{1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB, 1'b1, 5'd0, 5'd9, 5'd7,
                32'hA, 32'h11, 32'h77, 32'h11, 2'b00, 2'b00};
    tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0,
                32'hA, 32'h0, 32'hA, 32'h0, 2'b00, 2'b00};

    // Reset release and initial sweep; then every register must read zero.
    model_reset();
    #6;
    chk("reset_init_done", {31'd0, init_done_b}, 32'd0);
    chk("reset_busy", {30'd0, rd_busy_b}, 32'd0);
    rst = 1'b1;
    wait_init("reset_sweep_cycles");
    for (int i = 0; i < 16; i++) begin
      rd_idx = {5'(2 * i + 1), 5'(2 * i)};
      #1;
      chk($sformatf("zero_after_init x%0d", 2 * i), rd_data_b[31:0], 32'h0);
      chk($sformatf("zero_after_init x%0d", 2 * i + 1), rd_data_n[63:32], 32'h0);
      step();
    end

    // Hand vectors: bypass, port collision, x0, scoreboard set/clear ordering.
    for (int v = 0; v < 12; v++) begin
      wa_wen = tbl[v].wa_wen; wa_idx = tbl[v].wa_idx; wa_data = tbl[v].wa_data;
      wb_wen = tbl[v].wb_wen; wb_idx = tbl[v].wb_idx; wb_data = tbl[v].wb_data;
      iss_valid = tbl[v].iss; iss_idx = tbl[v].iss_idx;
      rd_idx = {tbl[v].r1, tbl[v].r0};
      @(negedge clk);
      chk($sformatf("vec%0d data_byp0", v), rd_data_b[31:0], tbl[v].eb0);
      chk($sformatf("vec%0d data_byp1", v), rd_data_b[63:32], tbl[v].eb1);
      chk($sformatf("vec%0d data_nb0", v), rd_data_n[31:0], tbl[v].en0);
      chk($sformatf("vec%0d data_nb1", v), rd_data_n[63:32], tbl[v].en1);
      chk($sformatf("vec%0d busy_byp", v), {30'd0, rd_busy_b}, {30'd0, tbl[v].bb});
      chk($sformatf("vec%0d busy_nb", v), {30'd0, rd_busy_n}, {30'd0, tbl[v].bn});
      @(posedge clk);
      model_step();
      #1;
    end
    idle();

    // Software clear: busy flushed, sweep repeats, old contents gone.
    wa_wen = 1'b1; wa_idx = 5'd3; wa_data = 32'h5A; iss_valid = 1'b1; iss_idx = 5'd9;
    step();
    idle();
    rd_idx = {5'd9, 5'd3};
    #1;
    chk("x3_before_clr", rd_data_b[31:0], 32'h5A);
    chk("x9_busy_before_clr", {31'd0, rd_busy_b[1]}, 32'd1);
    sw_clr = 1'b1;
    step();
    sw_clr = 1'b0;
    #1;
    chk("swclr_init_done", {31'd0, init_done_b}, 32'd0);
    chk("swclr_busy", {30'd0, rd_busy_b}, 32'd0);
    wait_init("swclr_sweep_cycles");
    rd_idx = {5'd9, 5'd3};
    #1;
    chk("x3_after_clr", rd_data_b[31:0], 32'h0);
    chk("x9_busy_after_clr", {31'd0, rd_busy_n[1]}, 32'd0);
    rd_idx = {5'd7, 5'd5};
    #1;
    chk("x5_after_clr", rd_data_n[31:0], 32'h0);

    // Reset in the middle of a sweep restarts it from the beginning.
    sw_clr = 1'b1;
    step();
    sw_clr = 1'b0;
    repeat (11) step();
    async_reset();
    wait_init("rst_mid_sweep_cycles");

    // Random traffic on a narrow index range to provoke collisions.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) async_reset();
      wa_wen    = 1'($urandom_range(0, 1));
      wa_idx    = 5'($urandom_range(0, 7));
      wa_data   = $urandom;
      wb_wen    = 1'($urandom_range(0, 1));
      wb_idx    = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      iss_valid = 1'($urandom_range(0, 1));
      iss_idx   = 5'($urandom_range(0, 7));
      sw_clr    = ($urandom_range(0, 79) == 0);
      rd_idx    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      step();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
